// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a client and the PS/2 host transmitter.
// The client drives a byte and a valid strobe; the transmitter reports when
// it can take a byte and pulses done or error once the frame is over.
interface ps2_host_tx_if;
    logic [7:0] iTxData;
    logic       iTxValid;
    logic       oTxReady;
    logic       oTxDone;
    logic       oTxErr;

    // Client side: offers bytes, observes status.
    modport master (
        output iTxData,
        output iTxValid,
        input  oTxReady,
        input  oTxDone,
        input  oTxErr
    );

    // Transmitter side.
    modport slave (
        input  iTxData,
        input  iTxValid,
        output oTxReady,
        output oTxDone,
        output oTxErr
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. It sends one command byte per request
// over the open-drain PS2_CLK/PS2_DATA pair. Both lines are driven only as
// active-high pull-low enables, and the top level builds the tristates.
// Frame sequence: inhibit (clock low), request-to-send (clock and data low),
// release the clock, then shift start/data/parity/stop on device falling
// edges, check the device ACK, and wait for the bus to go idle.
// Optional macro PS2TX_TIMEOUT_EN adds a per-frame watchdog that aborts a
// frame stuck in RTS, SEND, ACK or WAIT_IDLE.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES   = 5000,
    parameter int RTS_SETUP_CYCLES = 50
`ifdef PS2TX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES   = 750000
`endif
) (
    input  logic          iCLK_50,
    input  logic          reset,
    ps2_host_tx_if.slave  tx,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          oPS2_CLK_OE,
    output logic          oPS2_DATA_OE
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SEND,
        ST_ACK,
        ST_WAIT_IDLE,
        ST_RECOVER
    } state_t;

    localparam int CNT_MAX = (INHIBIT_CYCLES > RTS_SETUP_CYCLES) ? INHIBIT_CYCLES : RTS_SETUP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RTS_LAST     = CNT_W'(RTS_SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST    = CNT_W'(1);

`ifdef PS2TX_TIMEOUT_EN
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);
`endif

    // Line synchronisers and edge detect.
    logic clk_s1_q, clk_s2_q, clk_prev_q;
    logic data_s1_q, data_s2_q;
    logic clk_fe;
    logic lines_idle;

    // Frame state.
    state_t         state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [3:0]     bitcnt_q,  bitcnt_d;
    logic [7:0]     data_q,    data_d;
    logic           par_q,     par_d;
    logic           dout_oe_q, dout_oe_d;
    logic           done_q,    done_d;
    logic           err_q,     err_d;

`ifdef PS2TX_TIMEOUT_EN
    logic [19:0]    to_cnt_q,  to_cnt_d;
    logic           timeout_hit;
`endif

    // Two-flop synchronisers on both raw lines plus a delayed copy of the clock.
    always_ff @(posedge iCLK_50) begin
        // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
            data_s1_q  <= 1'b1;
            data_s2_q  <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk_in;
            clk_s2_q   <= clk_s1_q;
            clk_prev_q <= clk_s2_q;
            data_s1_q  <= ps2_data_in;
            data_s2_q  <= data_s1_q;
        end
    end

    assign clk_fe     = clk_prev_q & ~clk_s2_q;
    assign lines_idle = clk_s2_q & data_s2_q;

    // State register and frame datapath registers.
    always_ff @(posedge iCLK_50) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            dout_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef PS2TX_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            data_q    <= data_d;
            par_q     <= par_d;
            dout_oe_q <= dout_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef PS2TX_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
`endif
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        // NOTE: every _d starts from its _q (pulses from 0) so no path through this block can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        data_d    = data_q;
        par_d     = par_q;
        dout_oe_d = dout_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

`ifdef PS2TX_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        timeout_hit = 1'b0;
        if (state_q inside {ST_INHIBIT, ST_RTS, ST_SEND, ST_ACK, ST_WAIT_IDLE}) begin
            to_cnt_d = to_cnt_q + 20'd1;
        end
        // INHIBIT is self-timed and always shorter than the watchdog, so it is never aborted.
        timeout_hit = (state_q inside {ST_RTS, ST_SEND, ST_ACK, ST_WAIT_IDLE}) &&
                      (to_cnt_q == TIMEOUT_LAST);
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (tx.iTxValid) begin
                    data_d    = tx.iTxData;
                    par_d     = ~^tx.iTxData;
                    cnt_d     = '0;
                    bitcnt_d  = '0;
                    dout_oe_d = 1'b0;
                    state_d   = ST_INHIBIT;
`ifdef PS2TX_TIMEOUT_EN
                    to_cnt_d  = '0;
`endif
                end
            end

            ST_INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RTS;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RTS: begin
                if (cnt_q == RTS_LAST) begin
                    cnt_d     = '0;
                    bitcnt_d  = '0;
                    dout_oe_d = 1'b1;   // start bit stays on the line after the clock is released
                    state_d   = ST_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SEND: begin
                // The device samples on its rising edge, so data only moves right after a falling edge.
                if (clk_fe) begin
                    if (bitcnt_q < 4'd8) begin
                        dout_oe_d = ~data_q[bitcnt_q[2:0]];
                    end else if (bitcnt_q == 4'd8) begin
                        dout_oe_d = ~par_q;
                    end else begin
                        dout_oe_d = 1'b0;
                        state_d   = ST_ACK;
                    end
                    if (bitcnt_q != 4'hF) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
            end

            ST_ACK: begin
                if (clk_fe) begin
                    cnt_d = '0;
                    if (!data_s2_q) begin
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_RECOVER;
                    end
                end
            end

            ST_WAIT_IDLE, ST_RECOVER: begin
                // Both lines must read high for two consecutive cycles before the bus is free.
                if (lines_idle) begin
                    if (cnt_q == IDLE_LAST) begin
                        cnt_d   = '0;
                        done_d  = (state_q == ST_WAIT_IDLE);
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef PS2TX_TIMEOUT_EN
        // Watchdog expiry overrides anything else decided this cycle, including a coincident falling edge.
        if (timeout_hit) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            bitcnt_d  = '0;
            dout_oe_d = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b1;
        end
`endif
    end

    // Line enables and handshake outputs decoded from the current state.
    always_comb begin
        oPS2_CLK_OE  = (state_q == ST_INHIBIT) || (state_q == ST_RTS);
        oPS2_DATA_OE = (state_q == ST_RTS) || ((state_q == ST_SEND) && dout_oe_q);
        tx.oTxReady  = (state_q == ST_IDLE);
        tx.oTxDone   = done_q;
        tx.oTxErr    = err_q;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// a scoreboard holds the expected line frames and status pulses, and
// separate monitors compare what the device captured and what the DUT reports.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INHIBIT = 5000;
    localparam int RTS     = 50;
    localparam int HI_T    = 20;   // device clock high phase, system cycles
    localparam int LO_T    = 15;   // device clock low phase, system cycles
`ifdef PS2TX_TIMEOUT_EN
    localparam int TB_TIMEOUT = 12000;
`endif

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic reset;
    logic clk_oe, data_oe;
    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    logic ps2_clk_in, ps2_data_in;

    // Open-drain wired-AND of host and device pull-downs.
    assign ps2_clk_in  = ~(clk_oe | dev_clk_low);
    assign ps2_data_in = ~(data_oe | dev_data_low);

    ps2_host_tx_if tx_if();

    ps2_host_tx #(
        .INHIBIT_CYCLES   (INHIBIT),
        .RTS_SETUP_CYCLES (RTS)
`ifdef PS2TX_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES   (TB_TIMEOUT)
`endif
    ) dut (
        .iCLK_50      (clk),
        .reset        (reset),
        .tx           (tx_if),
        .ps2_clk_in   (ps2_clk_in),
        .ps2_data_in  (ps2_data_in),
        .oPS2_CLK_OE  (clk_oe),
        .oPS2_DATA_OE (data_oe)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard: expected status pulses (1 = error, 0 = done) and expected line frames.
    bit          exp_resp_q[$];
    logic [10:0] exp_frame_q[$];
    logic [10:0] cap_q[$];

    int dev_mode  = 0;   // 0 = ACK, 1 = no ACK, 2 = never clocks
    int dev_falls = 0;
    bit dev_busy  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference frame as the device sees it on successive samples:
    // start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = (($countones(b) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Device: samples data at the end of each high phase, then pulls the clock low.
    task automatic run_frame(input bit ack);
        logic [10:0] bits;
        dev_falls = 0;
        for (int k = 0; k < 11; k++) begin
            repeat (HI_T) @(posedge clk);
            #1;
            bits[k] = ps2_data_in;
            if (k == 10 && ack) begin
                dev_data_low = 1'b1;
                repeat (3) @(posedge clk);
                #1;
            end
            dev_clk_low = 1'b1;
            dev_falls++;
            repeat (LO_T) @(posedge clk);
            #1;
            dev_clk_low = 1'b0;
        end
        repeat (HI_T) @(posedge clk);
        #1;
        dev_data_low = 1'b0;
        cap_q.push_back(bits);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ps2_clk_in && !ps2_data_in) begin
                dev_busy = 1'b1;
                if (dev_mode == 2) begin
                    while (!ps2_data_in) @(posedge clk);
                end else begin
                    run_frame(dev_mode == 0);
                end
                dev_busy = 1'b0;
            end
        end
    end

    // Status monitor: every done/error pulse must match the next expected response.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_if.oTxDone || tx_if.oTxErr) begin
                check("done_err_exclusive", 32'(tx_if.oTxDone & tx_if.oTxErr), 32'd0);
                if (exp_resp_q.size() == 0) begin
                    fail_now($sformatf("unexpected_status done=%0b err=%0b", tx_if.oTxDone, tx_if.oTxErr));
                end else begin
                    automatic bit want_err = exp_resp_q.pop_front();
                    check("status_kind", {30'd0, tx_if.oTxDone, tx_if.oTxErr},
                          want_err ? 32'd1 : 32'd2);
                end
            end
        end
    end

    // Frame monitor: every frame the device captured must match the next expected frame.
    initial begin
        forever begin
            @(negedge clk);
            if (cap_q.size() > 0) begin
                automatic logic [10:0] cap = cap_q.pop_front();
                if (exp_frame_q.size() == 0) begin
                    fail_now($sformatf("unexpected_frame bits=0x%0h", cap));
                end else begin
                    check("frame_bits", 32'(cap), 32'(exp_frame_q.pop_front()));
                end
            end
        end
    end

    // Global time limit.
    initial begin
        #(20 * 150000);
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "bench time limit");
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(tx_if.oTxReady && !dev_busy) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) fail_now({name, "_idle_timeout"});
    endtask

    // Present one byte for exactly one accept edge.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        tx_if.iTxData  = b;
        tx_if.iTxValid = 1'b1;
        @(posedge clk);
        #1;
        tx_if.iTxValid = 1'b0;
    endtask

    task automatic send_expect_done(input logic [7:0] b);
        wait_idle("pre_send");
        exp_frame_q.push_back(frame_of(b));
        exp_resp_q.push_back(1'b0);
        send_byte(b);
        wait_idle("post_send");
    endtask

    initial begin
        int n;
        logic [7:0] b;
        logic [10:0] f;
        bit ready_seen;

        reset          = 1'b0;
        tx_if.iTxData  = 8'h00;
        tx_if.iTxValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_ready",   32'(tx_if.oTxReady), 32'd1);
        check("rst_clk_oe",  32'(clk_oe),         32'd0);
        check("rst_data_oe", 32'(data_oe),        32'd0);
        check("rst_done",    32'(tx_if.oTxDone),  32'd0);
        check("rst_err",     32'(tx_if.oTxErr),   32'd0);

        // 0xED with inhibit and RTS timing measured from the accept edge.
        exp_frame_q.push_back(frame_of(8'hED));
        exp_resp_q.push_back(1'b0);
        send_byte(8'hED);
        @(negedge clk);
        check("ready_after_accept", 32'(tx_if.oTxReady), 32'd0);
        n = 0;
        while (clk_oe && !data_oe && n < INHIBIT + 10) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", 32'(n), 32'(INHIBIT));
        check("rts_clk_oe",  32'(clk_oe),  32'd1);
        check("rts_data_oe", 32'(data_oe), 32'd1);
        n = 0;
        while (clk_oe && data_oe && n < RTS + 10) begin
            n++;
            @(negedge clk);
        end
        check("rts_len", 32'(n), 32'(RTS));
        check("start_bit_held", {30'd0, clk_oe, data_oe}, 32'd1);
        wait_idle("ed_frame");
        check("ready_after_ed", 32'(tx_if.oTxReady), 32'd1);

        // Parity corner cases.
        send_expect_done(8'h01);
        send_expect_done(8'h00);

        // Device withholds ACK.
        b = 8'($urandom);
        dev_mode = 1;
        exp_frame_q.push_back(frame_of(b));
        exp_resp_q.push_back(1'b1);
        send_byte(b);
        wait_idle("noack");
        check("noack_lines", {30'd0, clk_oe, data_oe}, 32'd0);
        check("noack_ready", 32'(tx_if.oTxReady), 32'd1);
        dev_mode = 0;

        // A second request during a frame is ignored.
        exp_frame_q.push_back(frame_of(8'hED));
        exp_resp_q.push_back(1'b0);
        send_byte(8'hED);
        ready_seen = 1'b0;
        tx_if.iTxData  = 8'h55;
        tx_if.iTxValid = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            ready_seen |= tx_if.oTxReady;
        end
        #1;
        tx_if.iTxValid = 1'b0;
        check("ready_low_while_busy", 32'(ready_seen), 32'd0);
        wait_idle("overlap");
        repeat (20) @(negedge clk);
        check("no_queued_send", 32'(clk_oe), 32'd0);

        // Reset at the fifth falling edge: lines released, no status pulse.
        b = 8'($urandom);
        f = frame_of(b);
        for (int k = 5; k < 11; k++) f[k] = 1'b1;
        exp_frame_q.push_back(f);
        send_byte(b);
        n = 0;
        while (dev_falls != 5 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 20000) fail_now("fe5_wait_timeout");
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_lines", {30'd0, clk_oe, data_oe}, 32'd0);
        check("midrst_ready", 32'(tx_if.oTxReady), 32'd1);
        send_expect_done(8'hFF);

        // Random bytes.
        for (int i = 0; i < 2; i++) send_expect_done(8'($urandom));

        // Device never clocks after RTS.
        wait_idle("pre_silent");
        dev_mode = 2;
        b = 8'($urandom);
`ifdef PS2TX_TIMEOUT_EN
        exp_resp_q.push_back(1'b1);
        send_byte(b);
        n = 1;
        while (n < TB_TIMEOUT + 100) begin
            @(posedge clk);
            #1;
            if (tx_if.oTxErr) break;
            n++;
        end
        check("timeout_latency", 32'(n), 32'(TB_TIMEOUT));
        check("timeout_lines", {30'd0, clk_oe, data_oe}, 32'd0);
        check("timeout_ready", 32'(tx_if.oTxReady), 32'd1);
`else
        send_byte(b);
        repeat (INHIBIT + RTS + 2000) @(negedge clk);
        check("stall_ready", 32'(tx_if.oTxReady), 32'd0);
        check("stall_lines", {30'd0, clk_oe, data_oe}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("stall_rst_lines", {30'd0, clk_oe, data_oe}, 32'd0);
`endif
        wait_idle("post_silent");
        dev_mode = 0;

        repeat (50) @(negedge clk);
        check("pending_resp",   32'(exp_resp_q.size()),  32'd0);
        check("pending_frames", 32'(exp_frame_q.size()), 32'd0);
        check("unread_frames",  32'(cap_q.size()),       32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
